// File: rtl/serial_alu_if.sv
// Bit-serial link between the processor and the ALU endpoint:
// packet bits flow in, result bits flow out.
interface serial_alu_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic out_data;
  logic out_last;
  logic out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/serial_alu.sv
// Serial ALU endpoint: assembles a 66-bit packet LSB-first, executes one of
// ADD/SUB/AND/OR on two 32-bit operands, and streams the 32-bit result LSB-first.
module serial_alu (
  input  logic        clk,
  input  logic        rst_n,
  serial_alu_if.slave bus
);
  localparam int REGISTER_SIZE = 32;
  localparam int OP_BITS       = 2;
  localparam int PACKET_BITS   = 2 * REGISTER_SIZE + OP_BITS;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    ST_RECEIVE,
    ST_EXECUTE,
    ST_TRANSMIT
  } state_t;

  state_t                     state_q, state_d;
  logic [6:0]                 cnt_q, cnt_d;
  logic [PACKET_BITS-1:0]     pkt_q, pkt_d;
  logic [REGISTER_SIZE-1:0]   res_q, res_d;

  logic [OP_BITS-1:0]         op_code;
  logic [REGISTER_SIZE-1:0]   op_1;
  logic [REGISTER_SIZE-1:0]   op_2;
  logic [REGISTER_SIZE-1:0]   alu_result;

  // Bits enter at the top, so the first-received op_code ends up in pkt_q[1:0].
  assign op_code = pkt_q[1:0];
  assign op_1    = pkt_q[REGISTER_SIZE+1:2];
  assign op_2    = pkt_q[PACKET_BITS-1:REGISTER_SIZE+2];

  always_comb begin
    alu_result = '0;
    case (op_code)
      OP_ADD:  alu_result = op_1 + op_2;
      OP_SUB:  alu_result = op_1 - op_2;
      OP_AND:  alu_result = op_1 & op_2;
      OP_OR:   alu_result = op_1 | op_2;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    res_d   = res_q;
    case (state_q)
      ST_RECEIVE: begin
        if (bus.in_valid) begin
          pkt_d = {bus.in_data, pkt_q[PACKET_BITS-1:1]};
          if (cnt_q == 7'(PACKET_BITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_EXECUTE;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_EXECUTE: begin
        res_d   = alu_result;
        cnt_d   = '0;
        state_d = ST_TRANSMIT;
      end
      ST_TRANSMIT: begin
        if (bus.out_ready) begin
          res_d = {1'b0, res_q[REGISTER_SIZE-1:1]};
          if (cnt_q == 7'(REGISTER_SIZE - 1)) begin
            cnt_d   = '0;
            state_d = ST_RECEIVE;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_RECEIVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RECEIVE;
      cnt_q   <= '0;
      pkt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      res_q   <= res_d;
    end
  end

  // All handshake outputs depend only on registered state, never on inputs.
  assign bus.in_ready  = (state_q == ST_RECEIVE);
  assign bus.out_valid = (state_q == ST_TRANSMIT);
  assign bus.out_data  = res_q[0];
  assign bus.out_last  = (state_q == ST_TRANSMIT) && (cnt_q == 7'(REGISTER_SIZE - 1));
endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: directed packets push expected results,
// a negedge monitor reassembles output words and compares them.
module tb_serial_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_alu_if bus();

  serial_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  bit gaps  = 1'b0;
  bit stall = 1'b0;
  int last_hs_cyc = 0;
  int b2b_gap     = 0;
  int overlap     = 0;

  int          bitidx = 0;
  logic [31:0] word   = '0;
  bit          lerr   = 1'b0;
  bit          held   = 1'b0;
  logic        hd, hl;
  logic [31:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: samples at negedge, when all inputs for the next edge are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      bitidx = 0;
      word   = '0;
      lerr   = 1'b0;
      held   = 1'b0;
    end else begin
      if (bus.in_ready && bus.out_valid) overlap++;
      if (held && bus.out_valid) begin
        check("stall_data", {31'b0, bus.out_data}, {31'b0, hd});
        check("stall_last", {31'b0, bus.out_last}, {31'b0, hl});
      end
      held = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        word[bitidx] = bus.out_data;
        if (bus.out_last != (bitidx == 31)) lerr = 1'b1;
        if (bitidx == 31 || bus.out_last) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %h expected none", word);
          end else begin
            e = exp_q.pop_front();
            check("result", word, e);
          end
          check("last_position_err", {31'b0, lerr}, 32'd0);
          last_hs_cyc = cyc + 1;
          bitidx = 0;
          lerr   = 1'b0;
          word   = '0;
        end else begin
          bitidx++;
        end
      end else if (bus.out_valid) begin
        held = 1'b1;
        hd   = bus.out_data;
        hl   = bus.out_last;
      end
    end
  end

  task automatic send_pkt(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int nbits, input bit push, input logic [31:0] expv, input bit hold);
    logic [65:0] v;
    bit accepted;
    v = {b, a, op};
    if (push) exp_q.push_back(expv);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      accepted = 1'b0;
      for (int t = 0; t < 300 && !accepted; t++) begin
        @(negedge clk);
        if (bus.in_ready) begin
          accepted = 1'b1;
          if (i == 0) b2b_gap = cyc + 1 - last_hs_cyc;
        end
        @(posedge clk);
        #1;
      end
      if (!accepted) begin
        total++;
        bad++;
        $display("FAIL in_accept_timeout: bit %0d not accepted, required within 300 cycles", i);
        bus.in_valid = 1'b0;
        return;
      end
    end
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, "_in_ready"},  {31'b0, bus.in_ready},  32'd1);
    check({name, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check({name, "_out_data"},  {31'b0, bus.out_data},  32'd0);
    check({name, "_out_last"},  {31'b0, bus.out_last},  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    send_pkt(2'd0, 32'd5, 32'd7, 66, 1'b1, 32'h0000000C, 1'b0);
    wait_drain();
    send_pkt(2'd1, 32'd3, 32'd5, 66, 1'b1, 32'hFFFFFFFE, 1'b0);
    wait_drain();
    send_pkt(2'd0, 32'hFFFFFFFF, 32'd1, 66, 1'b1, 32'h00000000, 1'b0);
    wait_drain();
    send_pkt(2'd2, 32'hF0F0F0F0, 32'hFF00FF00, 66, 1'b1, 32'hF000F000, 1'b0);
    wait_drain();
    send_pkt(2'd3, 32'hF0F0F0F0, 32'hFF00FF00, 66, 1'b1, 32'hFFF0FFF0, 1'b0);
    wait_drain();

    gaps  = 1'b1;
    stall = 1'b1;
    send_pkt(2'd0, 32'd5, 32'd7, 66, 1'b1, 32'h0000000C, 1'b0);
    wait_drain();
    send_pkt(2'd1, 32'd3, 32'd5, 66, 1'b1, 32'hFFFFFFFE, 1'b0);
    wait_drain();
    gaps  = 1'b0;
    stall = 1'b0;

    send_pkt(2'd0, 32'hAAAAAAAA, 32'h55555555, 40, 1'b0, 32'h0, 1'b0);
    do_reset("reset_mid_rx");
    send_pkt(2'd3, 32'h00000001, 32'h00000002, 66, 1'b1, 32'h00000003, 1'b0);
    wait_drain();

    send_pkt(2'd1, 32'd10, 32'd3, 66, 1'b0, 32'h0, 1'b0);
    for (int t = 0; t < 200 && bitidx < 5; t++) @(posedge clk);
    #1;
    do_reset("reset_mid_tx");

    send_pkt(2'd0, 32'h12345678, 32'h11111111, 66, 1'b1, 32'h23456789, 1'b1);
    send_pkt(2'd2, 32'hFFFF0000, 32'h12345678, 66, 1'b1, 32'h12340000, 1'b0);
    check("b2b_gap", b2b_gap, 32'd1);
    wait_drain();

    check("no_overlap", overlap, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
